poly_loader: RTL and testbench

POLY_LOADER -- requirements
Module: poly_loader

---
 rtl/poly_loader.sv | 140 ++++++++++++++
 tb/tb_poly_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_loader.sv
// poly_loader: packs a 16-bit coefficient stream into even/odd RAM write pairs; optional mod-Q reduction under LOADER_MODRED_EN.
// Write is registered one cycle after the odd beat; s_ready drops outside EVEN/ODD, so the host simply waits.
module poly_loader #(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        start,
  output logic        we,
  output logic [7:0]  address_ina,
  output logic [7:0]  address_inb,
  output logic [15:0] data_ina,
  output logic [15:0] data_inb,
  output logic        load_done,
  output logic        len_err,
  output logic        coef_err
);

  typedef enum logic [2:0] {IDLE, EVEN, ODD, HOLD, DONE} state_t;

  localparam logic [7:0] LAST_K = 8'(N / 2 - 1);

  state_t      state;
  logic [7:0]  k;
  logic [15:0] even_dat;
  logic        hs;
  logic [15:0] coef;
  logic        coef_bad;

  assign hs = s_valid & s_ready;

`ifdef LOADER_MODRED_EN
  localparam logic [16:0] Q1 = 17'(Q);
  localparam logic [16:0] Q2 = 17'(2 * Q);

  always_comb begin
    coef     = s_data;
    coef_bad = 1'b0;
    if ({1'b0, s_data} >= Q2) begin
      coef     = '0;
      coef_bad = 1'b1;
    end else if ({1'b0, s_data} >= Q1) begin
      coef = 16'({1'b0, s_data} - Q1);
    end
  end
`else
  assign coef     = s_data;
  assign coef_bad = 1'b0;
`endif

  // The final pair's write is presented while in HOLD; DONE follows one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      even_dat    <= '0;
      s_ready     <= 1'b0;
      start       <= 1'b0;
      we          <= 1'b0;
      address_ina <= '0;
      address_inb <= '0;
      data_ina    <= '0;
      data_inb    <= '0;
      load_done   <= 1'b0;
      len_err     <= 1'b0;
      coef_err    <= 1'b0;
    end else begin
      we        <= 1'b0;
      load_done <= 1'b0;
      if (state == IDLE) begin
        if (go) begin
          state    <= EVEN;
          k        <= '0;
          len_err  <= 1'b0;
          coef_err <= 1'b0;
          s_ready  <= 1'b1;
          start    <= 1'b1;
        end
      end else if (abort) begin
        state   <= IDLE;
        k       <= '0;
        s_ready <= 1'b0;
        start   <= 1'b0;
      end else begin
        case (state)
          EVEN: if (hs) begin
            coef_err <= coef_err | coef_bad;
            if (s_last) begin
              len_err <= 1'b1;
              state   <= IDLE;
              s_ready <= 1'b0;
              start   <= 1'b0;
            end else begin
              even_dat <= coef;
              state    <= ODD;
            end
          end
          ODD: if (hs) begin
            coef_err <= coef_err | coef_bad;
            if (s_last && k != LAST_K) begin
              len_err <= 1'b1;
              state   <= IDLE;
              s_ready <= 1'b0;
              start   <= 1'b0;
            end else begin
              we          <= 1'b1;
              address_ina <= {k[6:0], 1'b0};
              address_inb <= {k[6:0], 1'b1};
              data_ina    <= even_dat;
              data_inb    <= coef;
              k           <= k + 8'd1;
              if (k == LAST_K) begin
                len_err <= len_err | ~s_last;
                state   <= HOLD;
                s_ready <= 1'b0;
              end else begin
                state <= EVEN;
              end
            end
          end
          HOLD: begin
            state     <= DONE;
            start     <= 1'b0;
            load_done <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_loader.sv
// Bench for poly_loader: control-vector table, directed multi-cycle loads and random loads checked against a pair/RAM model.
module tb_poly_loader;
  localparam int N = 256;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0, abort = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, start, we, load_done, len_err, coef_err;
  logic [7:0]  address_ina, address_inb;
  logic [15:0] data_ina, data_inb;

  poly_loader #(.N(N), .Q(Q)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready), .start(start), .we(we),
    .address_ina(address_ina), .address_inb(address_inb), .data_ina(data_ina),
    .data_inb(data_inb), .load_done(load_done), .len_err(len_err), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  aa;
    logic [7:0]  ab;
    logic [15:0] da;
    logic [15:0] db;
  } wr_t;

  typedef struct {
    logic go, abort, vld, last;
    logic [15:0] dat;
    logic rdy, st, we;
    logic [7:0] aa, ab;
    logic [15:0] da, db;
    logic done, lerr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  int done_cnt;
  wr_t got_q[$];
  wr_t s1_q[$];
  logic [15:0] dat [N];
  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] red(input logic [15:0] c);
`ifdef LOADER_MODRED_EN
    if (int'(c) >= 2 * Q) return 16'd0;
    if (int'(c) >= Q) return 16'(int'(c) - Q);
`endif
    return c;
  endfunction

  function automatic bit red_bad(input logic [15:0] c);
`ifdef LOADER_MODRED_EN
    return int'(c) >= 2 * Q;
`else
    return (c != c);
`endif
  endfunction

  function automatic logic [53:0] all_outs();
    return {s_ready, start, we, address_ina, address_inb, data_ina, data_inb,
            load_done, len_err, coef_err};
  endfunction

  task automatic sample();
    if (we) begin
      got_q.push_back({address_ina, address_inb, data_ina, data_inb});
      last_we_cyc = cyc;
    end
    if (load_done) begin
      done_cnt++;
      check("done_one_after_final_write", {start, 32'(cyc - last_we_cyc)}, {1'b0, 32'd1});
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    sample();
  endtask

  function automatic vec_t mk(input logic g, a, v, l, input logic [15:0] d,
                              input logic r, st, w, input logic [7:0] aa, ab,
                              input logic [15:0] da, db, input logic dn, le);
    vec_t t;
    t.go = g; t.abort = a; t.vld = v; t.last = l; t.dat = d;
    t.rdy = r; t.st = st; t.we = w; t.aa = aa; t.ab = ab; t.da = da; t.db = db;
    t.done = dn; t.lerr = le;
    return t;
  endfunction

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid.
  task automatic run_load(input string tag, input int last_at, input int abort_at,
                          input int mode, input int rst_k);
    int beat, acc, exp_pairs;
    bit stop, err_last, miss_last, cerr, hs, rst_hit;
    got_q.delete();
    done_cnt = 0;
    beat = 0; acc = 0; stop = 0; err_last = 0; miss_last = 0; cerr = 0; rst_hit = 0;
    go = 1'b1;
    cycle();
    go = 1'b0;
    for (int c = 0; c < 4000 && !stop && beat < N; c++) begin
      if (rst_k >= 0 && got_q.size() == rst_k) begin
        rst = 1'b0;
        #1;
        check({tag, "_async_reset"}, 64'(all_outs()), 64'd0);
        rst_hit = 1;
        stop = 1;
      end else begin
        s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(0, 1));
        s_data  = dat[beat];
        s_last  = (beat == last_at);
        hs      = s_valid && s_ready;
        abort   = hs && (beat == abort_at);
        cycle();
        abort = 1'b0;
        if (hs) begin
          if (beat == abort_at) begin
            stop = 1;
            check({tag, "_abort_idle"}, {s_ready, start, we}, 3'b000);
          end else begin
            if (red_bad(dat[beat])) cerr = 1;
            if (beat == last_at && beat != N - 1) begin
              err_last = 1;
              stop = 1;
              check({tag, "_early_last_idle"}, {s_ready, start, we}, 3'b000);
            end else begin
              acc++;
            end
            if (beat == N - 1 && beat != last_at) miss_last = 1;
            beat++;
          end
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (rst_hit) begin
      cycle();
      check({tag, "_held_in_reset"}, 64'(all_outs()), 64'd0);
      rst = 1'b1;
      cycle();
      return;
    end
    if (!stop) check({tag, "_all_beats_accepted"}, beat, N);
    repeat (4) cycle();
    exp_pairs = acc / 2;
    check({tag, "_write_count"}, got_q.size(), exp_pairs);
    for (int p = 0; p < exp_pairs && p < got_q.size(); p++)
      check({tag, "_write"}, got_q[p],
            {8'(2 * p), 8'(2 * p + 1), red(dat[2 * p]), red(dat[2 * p + 1])});
    check({tag, "_load_done_count"}, done_cnt, (acc == N) ? 1 : 0);
    check({tag, "_len_err"}, len_err, err_last | miss_last);
    check({tag, "_coef_err"}, coef_err, cerr);
    check({tag, "_idle_after"}, {s_ready, start, we, load_done}, 4'b0000);
  endtask

  initial begin
    int diff;
    repeat (2) cycle();
    check("reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b1;
    cycle();

    tbl[0]  = mk(0,0,0,0,16'd0,  0,0,0,8'd0,8'd0,16'd0,16'd0,0,0);
    tbl[1]  = mk(0,1,0,0,16'd0,  0,0,0,8'd0,8'd0,16'd0,16'd0,0,0);
    tbl[2]  = mk(1,1,0,0,16'd0,  1,1,0,8'd0,8'd0,16'd0,16'd0,0,0);
    tbl[3]  = mk(1,0,1,0,16'd7,  1,1,0,8'd0,8'd0,16'd0,16'd0,0,0);
    tbl[4]  = mk(0,0,1,0,16'd9,  1,1,1,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[5]  = mk(0,0,0,0,16'd0,  1,1,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[6]  = mk(0,0,1,0,16'd11, 1,1,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[7]  = mk(0,1,1,0,16'd13, 0,0,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[8]  = mk(0,0,1,0,16'd0,  0,0,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[9]  = mk(1,0,0,0,16'd0,  1,1,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[10] = mk(0,0,1,1,16'd5,  0,0,0,8'd0,8'd1,16'd7,16'd9,0,1);
    tbl[11] = mk(0,0,0,0,16'd0,  0,0,0,8'd0,8'd1,16'd7,16'd9,0,1);
    tbl[12] = mk(1,0,0,0,16'd0,  1,1,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[13] = mk(0,1,0,0,16'd0,  0,0,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[14] = mk(1,0,0,0,16'd0,  1,1,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[15] = mk(0,0,1,0,16'd2,  1,1,0,8'd0,8'd1,16'd7,16'd9,0,0);
    tbl[16] = mk(0,0,1,0,16'd3,  1,1,1,8'd0,8'd1,16'd2,16'd3,0,0);
    tbl[17] = mk(0,1,0,0,16'd0,  0,0,0,8'd0,8'd1,16'd2,16'd3,0,0);
    for (int i = 0; i < 18; i++) begin
      go = tbl[i].go; abort = tbl[i].abort; s_valid = tbl[i].vld;
      s_last = tbl[i].last; s_data = tbl[i].dat;
      cycle();
      check($sformatf("vec%0d", i),
            {s_ready, start, we, address_ina, address_inb, data_ina, data_inb, load_done, len_err},
            {tbl[i].rdy, tbl[i].st, tbl[i].we, tbl[i].aa, tbl[i].ab, tbl[i].da, tbl[i].db,
             tbl[i].done, tbl[i].lerr});
    end
    go = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    cycle();

    for (int i = 0; i < N; i++) dat[i] = 16'(i);
    run_load("s1", N - 1, -1, 0, -1);
    check("s1_final_write", (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0,
          {8'd254, 8'd255, 16'd254, 16'd255});
    s1_q = got_q;
    run_load("s2", N - 1, -1, 1, -1);
    diff = (s1_q.size() == got_q.size()) ? 0 : 1;
    for (int i = 0; i < s1_q.size() && i < got_q.size(); i++)
      if (s1_q[i] != got_q[i]) diff++;
    check("s2_same_as_s1", diff, 0);

    run_load("s3", 9, -1, 0, -1);
    check("s3_pairs", got_q.size(), 4);
    run_load("s4", N - 1, 100, 0, -1);
    check("s4_no_pair50", got_q.size(), 50);
    run_load("s4_reload", N - 1, -1, 0, -1);

`ifdef LOADER_MODRED_EN
    dat[0] = 16'd3328; dat[1] = 16'd3329; dat[2] = 16'd6657; dat[3] = 16'd6658;
    run_load("s5", N - 1, -1, 0, -1);
    check("s5_pair0", (got_q.size() > 0) ? got_q[0] : '0, {8'd0, 8'd1, 16'd3328, 16'd0});
    check("s5_pair1", (got_q.size() > 1) ? got_q[1] : '0, {8'd2, 8'd3, 16'd3328, 16'd0});
    check("s5_coef_err", coef_err, 1'b1);
`endif

    for (int i = 0; i < N; i++) dat[i] = 16'($urandom);
    run_load("s6", N - 1, -1, 0, 40);
    run_load("s6_restart", N - 1, -1, 2, -1);

    for (int t = 0; t < 6; t++) begin
      int la, ab;
      for (int i = 0; i < N; i++) dat[i] = 16'($urandom_range(0, 9000));
      case (t % 3)
        0: la = N - 1;
        1: la = -1;
        default: la = $urandom_range(0, N - 2);
      endcase
      ab = (t == 4) ? $urandom_range(1, N - 2) : -1;
      run_load($sformatf("rand%0d", t), la, ab, 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
